// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-timing helper and
// parity helper used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Whole clk cycles per serial bit (integer divide, truncating).
  function automatic int clks_per_bit(input int input_clock, input int baud_rate);
    return input_clock / baud_rate;
  endfunction

  // Even-parity bit for a data byte: 1 when the byte has an odd number of ones.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for asynchronous single-bit inputs. All stages reset
// to RESET_VAL so an idle-high line does not look like a falling edge
// coming out of reset. STAGES must be at least 2.
module uart_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the async input through the flop chain; sync reset to RESET_VAL.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= {STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined). Detects the
// start edge on the synchronised line, samples every bit at mid-bit and
// reports the byte with one-cycle valid / error strobes. A stop bit seen
// low parks the FSM in BREAK until the line idles high again, so a held-low
// line is reported as one framing error instead of a stream of 0x00 bytes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK = 12_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_in,
  output logic [7:0] in_data,
  output logic       data_valid,
  output logic       frame_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(INPUT_CLOCK, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                      rx_s;
  rx_state_e                 state_r, state_n;
  logic [CNT_W-1:0]          cnt_r, cnt_n;
  logic [2:0]                idx_r, idx_n;
  logic [UART_DATA_BITS-1:0] shift_r, shift_n;
  logic [UART_DATA_BITS-1:0] data_r, data_n;
  logic                      valid_r, valid_n;
  logic                      ferr_r, ferr_n;
  logic                      busy_r;
`ifdef UART_RX_PARITY_EN
  logic                      ppend_r, ppend_n;
  logic                      perr_r, perr_n;
`endif

  uart_sync #(
    .STAGES    (2),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_in),
    .q     (rx_s)
  );

  // Next-state, datapath and strobe decode for the receive FSM.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    shift_n = shift_r;
    data_n  = data_r;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    ppend_n = ppend_r;
    perr_n  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        cnt_n = '0;
        idx_n = 3'd0;
`ifdef UART_RX_PARITY_EN
        ppend_n = 1'b0;
`endif
        if (!rx_s) begin
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_n = '0;
          idx_n = 3'd0;
          // Line back high at mid-start: treat as a glitch.
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == CNT_FULL) begin
          cnt_n          = '0;
          shift_n[idx_r] = rx_s;
          if (idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx_r + 3'd1;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_r == CNT_FULL) begin
          cnt_n   = '0;
          ppend_n = (rx_s != even_parity(shift_r));
          state_n = STOP;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (cnt_r == CNT_FULL) begin
          cnt_n = '0;
`ifdef UART_RX_PARITY_EN
          perr_n = ppend_r;
`endif
          if (rx_s) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (!ppend_r) begin
              data_n  = shift_r;
              valid_n = 1'b1;
            end else begin
              data_n  = data_r;
              valid_n = 1'b0;
            end
`else
            data_n  = shift_r;
            valid_n = 1'b1;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rx_s) begin
          state_n = IDLE;
        end else begin
          state_n = BREAK;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = 3'd0;
      end
    endcase
  end

  // State, datapath and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      ppend_r <= 1'b0;
      perr_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      shift_r <= shift_n;
      data_r  <= data_n;
      valid_r <= valid_n;
      ferr_r  <= ferr_n;
      busy_r  <= (state_n != IDLE);
`ifdef UART_RX_PARITY_EN
      ppend_r <= ppend_n;
      perr_r  <= perr_n;
`endif
    end
  end

  assign in_data     = data_r;
  assign data_valid  = valid_r;
  assign frame_error = ferr_r;
  assign busy        = busy_r;
`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_r;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at default parameters (104 clks/bit). Expected
// bytes go into a scoreboard queue as frames are driven and are popped by
// a monitor on every data_valid strobe. Define UART_RX_PARITY_EN to run the
// parity cases.
module tb_uart_rx;

  localparam int CPB = 104;

  logic       clk;
  logic       reset;
  logic       uart_in;
  logic [7:0] in_data;
  logic       data_valid;
  logic       frame_error;
  logic       parity_error;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(
    .INPUT_CLOCK (12_000_000),
    .BAUD_RATE   (115_200)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_in      (uart_in),
    .in_data      (in_data),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: count strobes, check valid width and scoreboard contents.
  always @(negedge clk) begin
    if (frame_error) ferr_cnt++;
    if (parity_error) perr_cnt++;
    if (data_valid) begin
      valid_cnt++;
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_width: data_valid high 2 cycles in a row, required 1");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got in_data=%02h, required no strobe", in_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (in_data !== e) begin
          errors++;
          $display("FAIL rx_byte: got %02h, required %02h", in_data, e);
        end
      end
    end
    prev_valid = data_valid;
  end

  task automatic drive_bit(input logic v, input int clks);
    @(posedge clk);
    #1 uart_in = v;
    repeat (clks - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int clks, input logic stop_v,
                            input logic par_ok);
    if (stop_v && par_ok) exp_q.push_back(b);
    drive_bit(1'b0, clks);
    for (int i = 0; i < 8; i++) drive_bit(b[i], clks);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_ok ? ^b : ~(^b), clks);
`endif
    drive_bit(stop_v, clks);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 uart_in = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    uart_in = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_data, data_valid, frame_error, parity_error, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got data=%02h v=%b fe=%b pe=%b busy=%b, required all 0",
               in_data, data_valid, frame_error, parity_error, busy);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, CPB, 1'b1, 1'b1);
    send_frame(8'hA3, CPB, 1'b1, 1'b1);
    idle(30);
    last_good = 8'hA3;
    checks++;
    if (valid_cnt - v0 !== 2) begin
      errors++;
      $display("FAIL b2b_valid_count: got %0d, required 2", valid_cnt - v0);
    end
    checks++;
    if (ferr_cnt !== f0) begin
      errors++;
      $display("FAIL b2b_frame_error: got %0d, required 0", ferr_cnt - f0);
    end
    checks++;
    if (in_data !== 8'hA3) begin
      errors++;
      $display("FAIL b2b_in_data: got %02h, required a3", in_data);
    end
  endtask

  task automatic test_glitch;
    int v0, f0, busy_cycles;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_cycles = 0;
    @(posedge clk);
    #1 uart_in = 1'b0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (i == 30) uart_in = 1'b1;
      if (busy) busy_cycles++;
    end
    checks++;
    if (busy_cycles > 52 || busy_cycles == 0) begin
      errors++;
      $display("FAIL glitch_busy: got %0d busy cycles, required 1..52", busy_cycles);
    end
    checks++;
    if (valid_cnt !== v0 || ferr_cnt !== f0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_strobes: got dv=%0d fe=%0d busy=%b, required 0 0 0",
               valid_cnt - v0, ferr_cnt - f0, busy);
    end
  endtask

  task automatic test_break;
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, CPB, 1'b0, 1'b1);
    repeat (2000) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ferr_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL break_ferr_count: got %0d, required 1", ferr_cnt - f0);
    end
    checks++;
    if (valid_cnt !== v0) begin
      errors++;
      $display("FAIL break_no_valid: got %0d strobes, required 0", valid_cnt - v0);
    end
    checks++;
    if (in_data !== last_good) begin
      errors++;
      $display("FAIL break_in_data: got %02h, required %02h", in_data, last_good);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL break_busy: got %b, required 1", busy);
    end
    idle(20);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ferr_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL break_release: got busy=%b fe=%0d, required 0 1", busy, ferr_cnt - f0);
    end
    send_frame(8'h81, CPB, 1'b1, 1'b1);
    idle(30);
    last_good = 8'h81;
    checks++;
    if (valid_cnt - v0 !== 1 || in_data !== 8'h81) begin
      errors++;
      $display("FAIL after_break: got dv=%0d data=%02h, required 1 81", valid_cnt - v0, in_data);
    end
  endtask

  task automatic test_reset_midframe;
    int v0, f0;
    logic [7:0] b;
    b = 8'hFF;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
    drive_bit(b[4], 50);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_data, data_valid, frame_error, parity_error, busy} !== 12'h000) begin
      errors++;
      $display("FAIL midframe_reset_outputs: got data=%02h v=%b fe=%b pe=%b busy=%b, required all 0",
               in_data, data_valid, frame_error, parity_error, busy);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    last_good = 8'h00;
    drive_bit(b[4], 50);
    for (int i = 5; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(1'b1, CPB);
    idle(200);
    checks++;
    if (valid_cnt !== v0 || ferr_cnt !== f0 || in_data !== 8'h00) begin
      errors++;
      $display("FAIL aborted_frame: got dv=%0d fe=%0d data=%02h, required 0 0 00",
               valid_cnt - v0, ferr_cnt - f0, in_data);
    end
    send_frame(8'h12, CPB, 1'b1, 1'b1);
    idle(30);
    checks++;
    if (valid_cnt - v0 !== 1 || in_data !== 8'h12) begin
      errors++;
      $display("FAIL after_reset: got dv=%0d data=%02h, required 1 12", valid_cnt - v0, in_data);
    end
  endtask

  task automatic test_baud_tolerance;
    int v0;
    v0 = valid_cnt;
    send_frame(8'hC9, 106, 1'b1, 1'b1);
    idle(60);
    checks++;
    if (valid_cnt - v0 !== 1 || in_data !== 8'hC9) begin
      errors++;
      $display("FAIL baud_plus2: got dv=%0d data=%02h, required 1 c9", valid_cnt - v0, in_data);
    end
    send_frame(8'hC9, 102, 1'b1, 1'b1);
    idle(60);
    checks++;
    if (valid_cnt - v0 !== 2 || in_data !== 8'hC9) begin
      errors++;
      $display("FAIL baud_minus2: got dv=%0d data=%02h, required 2 c9", valid_cnt - v0, in_data);
    end
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int v0, p0, f0;
    v0 = valid_cnt;
    p0 = perr_cnt;
    f0 = ferr_cnt;
    send_frame(8'h07, CPB, 1'b1, 1'b1);
    idle(30);
    checks++;
    if (valid_cnt - v0 !== 1 || perr_cnt !== p0 || in_data !== 8'h07) begin
      errors++;
      $display("FAIL parity_good: got dv=%0d pe=%0d data=%02h, required 1 0 07",
               valid_cnt - v0, perr_cnt - p0, in_data);
    end
    send_frame(8'h07, CPB, 1'b1, 1'b0);
    idle(30);
    checks++;
    if (valid_cnt - v0 !== 1 || perr_cnt - p0 !== 1 || ferr_cnt !== f0) begin
      errors++;
      $display("FAIL parity_bad: got dv=%0d pe=%0d fe=%0d, required 1 1 0",
               valid_cnt - v0, perr_cnt - p0, ferr_cnt - f0);
    end
`else
    checks++;
    if (perr_cnt !== 0) begin
      errors++;
      $display("FAIL parity_tied_low: got %0d strobes, required 0", perr_cnt);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    uart_in = 1'b1;
    test_reset();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_baud_tolerance();
    test_parity();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d bytes pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; receive-side counterpart of uart_tx, sharing its INPUT_CLOCK/BAUD_RATE parameterisation.
- Synchronises the asynchronous serial input, detects the start bit, samples each bit at mid-bit, and presents the received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the host logic; host logic has no backpressure.

Parameters:
- INPUT_CLOCK, 12_000_000, clk frequency in Hz
- BAUD_RATE, 115_200, serial bit rate in baud

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- uart_in  input  1  asynchronous serial line, idle high
- in_data  output  8  last received byte, LSB received first
- data_valid  output  1  one-cycle strobe: in_data updated with a good frame
- frame_error  output  1  one-cycle strobe: stop bit sampled low
- parity_error  output  1  one-cycle strobe: parity mismatch (tied 0 without the macro)
- busy  output  1  high whenever the state machine is not IDLE

Behaviour:
- Constants:
  - CLKS_PER_BIT = INPUT_CLOCK / BAUD_RATE (integer divide; 104 at defaults).
  - HALF_BIT = CLKS_PER_BIT / 2 (52).
  - Bit counter width is $clog2(CLKS_PER_BIT).
- Synchroniser: uart_in passes through 2 flops, both reset to 1. All decisions use the synchronised signal rx_s, which lags the pin by 2 cycles.
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; counters clear.
  - in_data=8'h00; data_valid, frame_error, parity_error and busy are all 0.
  - Reset mid-frame aborts the frame with no strobe.
- States:
  - IDLE: waits for rx_s==0, then goes to START with the bit counter cleared.
  - START: counts to HALF_BIT-1, then resamples rx_s.
    - rx_s==1: false start; return to IDLE, no strobe.
    - rx_s==0: go to DATA, bit counter cleared, bit index 0.
  - DATA: at each count CLKS_PER_BIT-1, sample rx_s into shift register position [index], LSB first. After index 7, go to STOP (or PARITY when the macro is set).
  - STOP: at count CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: on the next cycle in_data takes the shift register, data_valid=1 for exactly 1 cycle, state returns to IDLE.
    - rx_s==0: frame_error=1 for 1 cycle; in_data is unchanged; go to BREAK.
  - BREAK: waits for rx_s==1, then goes to IDLE. This prevents a held-low line from being read as repeated 0x00 frames.
- Latency: data_valid rises 1 cycle after the mid-stop-bit sample, about 9.5 bit times after the start edge plus 2 synchroniser cycles.
- Back-to-back frames: from IDLE after a good stop, a start edge is accepted immediately. A new start arriving within the second half of the stop bit is therefore still detected.
- Overrun: no handshake. in_data holds until the next good frame; the host must capture it on data_valid.
- busy is high in START, DATA, PARITY, STOP and BREAK.
- Strobes are mutually exclusive per frame except parity_error, which may coincide with frame_error.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit at CLKS_PER_BIT-1.
  - On mismatch, parity_error pulses together with the STOP outcome strobe, and data_valid is suppressed.
  - Frame length is 11 bits.
- Undefined: no PARITY state; parity_error is constant 0; frame length is 10 bits.

Decomposition:
- Package uart_pkg holds:
  - rx state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - function clks_per_bit(input_clock, baud_rate), shared with uart_tx.
  - UART_DATA_BITS=8.
- Sub-module uart_sync: parameterised N-flop synchroniser (default 2, reset value 1), reusable by other async inputs.

Test Plan (defaults; 104 clks/bit; each case 8N1 unless noted):
- Send 0x55 then 0xA3 back-to-back, no idle gap:
  - data_valid pulses twice, 1 cycle each.
  - in_data=0x55, then 0xA3.
  - frame_error never asserts.
- Low glitch of 30 clks on idle line: stays in IDLE after the START resample; no strobes; busy high ≤ 52 cycles.
- Frame 0x3C with stop bit driven low, then line held low 2000 clks, then released:
  - frame_error pulses once; in_data keeps its prior value.
  - No further strobes until the line returns high.
  - The next frame 0x81 is received correctly.
- Assert reset during bit 4 of frame 0xFF, release, then send 0x12:
  - Outputs all 0 during reset; no strobe from the aborted frame.
  - 0x12 is received correctly.
- Baud tolerance: send 0xC9 at +2% and -2% bit period: in_data=0xC9 both times.
- With UART_RX_PARITY_EN:
  - Send 0x07 with correct even parity (1): data_valid pulses.
  - Send 0x07 with wrong parity (0): parity_error pulses, data_valid stays 0.
